// File: rtl/pipe_array_mult.sv
// Pipelined carry-save array multiplier, unsigned or Baugh-Wooley signed per operation.
// Partial-product rows are spread over STAGES register stages; the last stage resolves the carries.
module pipe_array_mult #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    localparam int PW    = 2 * WIDTH;
    localparam int GROUP = (WIDTH + STAGES - 1) / STAGES;
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    // Handshake: a transfer happens on any cycle where valid && ready. The whole pipe
    // moves together when the output register is empty or being drained, otherwise
    // every stage holds; in_ready mirrors that and is combinational from out_ready.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Row j of the partial-product array; signed mode inverts the MSB row and column
    // except the corner bit.
    function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] x,
                                             input logic             yj,
                                             input logic             sgn,
                                             input int               j);
        logic [WIDTH-1:0] bits;
        bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bits[i] = x[i] & yj;
            if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1)))
                bits[i] = ~bits[i];
        end
        return PW'(bits) << j;
    endfunction

    function automatic logic [2*PW-1:0] csa_group(input logic [PW-1:0]    s_in,
                                                  input logic [PW-1:0]    c_in,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             sgn,
                                                  input int               grp);
        logic [PW-1:0] s, c, r, s_nx;
        s = s_in;
        c = c_in;
        r = '0;
        s_nx = '0;
        for (int k = 0; k < GROUP; k++) begin
            if (grp * GROUP + k < WIDTH) begin
                r    = pp_row(x, y[grp*GROUP+k], sgn, grp * GROUP + k);
                s_nx = s ^ c ^ r;
                c    = ((s & c) | (s & r) | (c & r)) << 1;
                s    = s_nx;
            end
        end
        return {s, c};
    endfunction

    generate
        if (STAGES == 1) begin : g_single
            logic [PW-1:0] fs, fc;

            always_comb begin
                {fs, fc} = csa_group(is_signed ? BW_CONST : '0, '0, a, b, is_signed, 0);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    product   <= '0;
                end else if (advance) begin
                    out_valid <= in_valid;
                    if (in_valid)
                        product <= fs + fc;
                end
            end
        end else begin : g_multi
            logic [STAGES-2:0] vld_r;
            logic [STAGES-2:0] sgn_r;
            logic [WIDTH-1:0]  a_r   [STAGES-1];
            logic [WIDTH-1:0]  b_r   [STAGES-1];
            logic [PW-1:0]     sum_r [STAGES-1];
            logic [PW-1:0]     car_r [STAGES-1];
            logic [PW-1:0]     nsum  [STAGES];
            logic [PW-1:0]     ncar  [STAGES];

            // Stage 0 seeds the sum vector with the Baugh-Wooley correction constant.
            always_comb begin
                {nsum[0], ncar[0]} = csa_group(is_signed ? BW_CONST : '0, '0, a, b, is_signed, 0);
                for (int s = 1; s < STAGES; s++)
                    {nsum[s], ncar[s]} = csa_group(sum_r[s-1], car_r[s-1], a_r[s-1], b_r[s-1],
                                                   sgn_r[s-1], s);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_r     <= '0;
                    sgn_r     <= '0;
                    out_valid <= 1'b0;
                    product   <= '0;
                    for (int s = 0; s < STAGES - 1; s++) begin
                        a_r[s]   <= '0;
                        b_r[s]   <= '0;
                        sum_r[s] <= '0;
                        car_r[s] <= '0;
                    end
                end else if (advance) begin
                    vld_r[0] <= in_valid;
                    if (in_valid) begin
                        a_r[0]   <= a;
                        b_r[0]   <= b;
                        sgn_r[0] <= is_signed;
                        sum_r[0] <= nsum[0];
                        car_r[0] <= ncar[0];
                    end
                    for (int s = 1; s < STAGES - 1; s++) begin
                        vld_r[s] <= vld_r[s-1];
                        sgn_r[s] <= sgn_r[s-1];
                        a_r[s]   <= a_r[s-1];
                        b_r[s]   <= b_r[s-1];
                        sum_r[s] <= nsum[s];
                        car_r[s] <= ncar[s];
                    end
                    out_valid <= vld_r[STAGES-2];
                    product   <= nsum[STAGES-1] + ncar[STAGES-1];
                end
            end
        end
    endgenerate

endmodule
